// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage memory sequencing controller.
package mem_stage_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/mem_tmo_counter.sv
// Wait-cycle down-counter for the MEM-stage transaction abort; o_expire flags the
// WAIT cycle in which the count reaches zero without an ack.
module mem_tmo_counter #(
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expire
);

  localparam int unsigned CntW = $clog2(TMO_CYCLES + 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CntW'(TMO_CYCLES);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CntW'(1);
    end
  end

  // This decrement is the one that lands on zero.
  assign o_expire = i_dec && (r_cnt <= CntW'(1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: one req/ack memory transaction per load/store, stalling the
// pipeline meanwhile. Optional abort counter enabled by defining MEM_TIMEOUT_EN.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] Addr_i,
  input  logic [DATA_W-1:0] WrData_i,
  input  logic              Mem_ack_i,
  input  logic [DATA_W-1:0] Mem_rdata_i,
  output logic              Mem_req_o,
  output logic              Mem_we_o,
  output logic [ADDR_W-1:0] Mem_addr_o,
  output logic [DATA_W-1:0] Mem_wdata_o,
  output logic              Stall_o,
  output logic              Bubble_o,
  output logic [DATA_W-1:0] Read_Data_o,
  output logic              Timeout_o
);

  state_e            r_state;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              w_acc;
  logic              w_stall;
  logic              w_expire;

  assign w_acc = MemRead_i | MemWrite_i;

`ifdef MEM_TIMEOUT_EN
  logic r_timeout;

  mem_tmo_counter #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_tmo (
    .i_clk    (clk_i),
    .i_rst_n  (rst_i),
    .i_load   ((r_state == StIdle) && w_acc),
    .i_dec    ((r_state == StWait) && !Mem_ack_i),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_timeout <= 1'b0;
    end else if ((r_state == StWait) && !Mem_ack_i && w_expire) begin
      r_timeout <= 1'b1;
    end
  end

  assign Timeout_o = r_timeout;
`else
  assign w_expire  = 1'b0;
  assign Timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= StIdle;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_acc) begin
            r_state <= StWait;
            r_req   <= 1'b1;
            r_we    <= MemWrite_i;  // read+write together is a store
            r_addr  <= Addr_i;
            r_wdata <= WrData_i;
          end
        end
        StWait: begin
          if (Mem_ack_i) begin
            r_state <= StDone;
            r_req   <= 1'b0;
            if (!r_we) r_rdata <= Mem_rdata_i;
          end else if (w_expire) begin
            r_state <= StDone;
            r_req   <= 1'b0;
            r_rdata <= '0;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // DONE releases the stall so the finished instruction leaves EX/MEM without re-issue.
  assign w_stall = rst_i && (((r_state == StIdle) && w_acc) || (r_state == StWait));

  assign Stall_o     = w_stall;
  assign Bubble_o    = w_stall;
  assign Mem_req_o   = r_req;
  assign Mem_we_o    = r_we;
  assign Mem_addr_o  = r_addr;
  assign Mem_wdata_o = r_wdata;
  assign Read_Data_o = r_rdata;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl; the timeout section follows MEM_TIMEOUT_EN.
module tb_mem_stage_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned Tmo = 4;
`else
  localparam int unsigned Tmo = 255;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i, Mem_ack_i;
  logic [31:0] Addr_i, WrData_i, Mem_rdata_i;
  logic        Mem_req_o, Mem_we_o, Stall_o, Bubble_o, Timeout_o;
  logic [31:0] Mem_addr_o, Mem_wdata_o, Read_Data_o;

  int n_pass = 0;
  int n_chk  = 0;
  int ns, nr, nb;

  always #5 clk_i = ~clk_i;

  mem_stage_ctrl #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .TMO_CYCLES (Tmo)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .Addr_i      (Addr_i),
    .WrData_i    (WrData_i),
    .Mem_ack_i   (Mem_ack_i),
    .Mem_rdata_i (Mem_rdata_i),
    .Mem_req_o   (Mem_req_o),
    .Mem_we_o    (Mem_we_o),
    .Mem_addr_o  (Mem_addr_o),
    .Mem_wdata_o (Mem_wdata_o),
    .Stall_o     (Stall_o),
    .Bubble_o    (Bubble_o),
    .Read_Data_o (Read_Data_o),
    .Timeout_o   (Timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Presents one memory instruction and follows it until the DONE cycle (stall low);
  // ack is pulsed on WAIT cycle ack_at (0 = never). Returns stall/req cycle counts and
  // the number of cycles where Bubble_o differed from Stall_o.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ack_at, input logic [31:0] rdata,
                         input bit mutate, output int n_stall, output int n_req,
                         output int n_bub);
    int wk = 0;
    @(negedge clk_i);
    MemRead_i = rd; MemWrite_i = wr; Addr_i = addr; WrData_i = wdata; Mem_ack_i = 1'b0;
    n_stall = 0; n_req = 0; n_bub = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (Bubble_o !== Stall_o) n_bub++;
      if (Stall_o !== 1'b1) break;
      n_stall++;
      if (Mem_req_o === 1'b1) begin
        n_req++;
        wk++;
        Mem_ack_i   = (wk == ack_at);
        Mem_rdata_i = rdata;
        if (mutate) begin
          Addr_i = ~addr; WrData_i = ~wdata; MemWrite_i = ~wr;
        end
      end
      @(negedge clk_i);
      Mem_ack_i = 1'b0;
      Mem_rdata_i = 32'h0;
    end
  endtask

  initial begin
    rst_i = 1'b0; MemRead_i = 1'b1; MemWrite_i = 1'b0; Addr_i = 32'h0; WrData_i = 32'h0;
    Mem_ack_i = 1'b0; Mem_rdata_i = 32'h0;
    #2;
    check("rst_req", {31'd0, Mem_req_o}, 32'd0);
    check("rst_we", {31'd0, Mem_we_o}, 32'd0);
    check("rst_addr", Mem_addr_o, 32'd0);
    check("rst_wdata", Mem_wdata_o, 32'd0);
    check("rst_rdata", Read_Data_o, 32'd0);
    check("rst_tmo", {31'd0, Timeout_o}, 32'd0);
    check("rst_stall", {31'd0, Stall_o}, 32'd0);
    check("rst_bubble", {31'd0, Bubble_o}, 32'd0);
    @(negedge clk_i);
    MemRead_i = 1'b0; rst_i = 1'b1;

    // Load, ack on third WAIT cycle
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, ns, nr, nb);
    check("ld_stall_cycles", ns, 4);
    check("ld_req_cycles", nr, 3);
    check("ld_bubble_eq", nb, 0);
    check("ld_rdata", Read_Data_o, 32'hDEAD_BEEF);
    check("ld_bubble_done", {31'd0, Bubble_o}, 32'd0);
    check("ld_req_done", {31'd0, Mem_req_o}, 32'd0);
    check("ld_addr", Mem_addr_o, 32'h10);
    check("ld_we", {31'd0, Mem_we_o}, 32'd0);

    // Store, ack on first WAIT cycle; rdata on the bus must be ignored
    run_txn(1'b0, 1'b1, 32'h20, 32'h1234_5678, 1, 32'hFFFF_FFFF, 1'b0, ns, nr, nb);
    check("st_stall_cycles", ns, 2);
    check("st_req_cycles", nr, 1);
    check("st_we", {31'd0, Mem_we_o}, 32'd1);
    check("st_addr", Mem_addr_o, 32'h20);
    check("st_wdata", Mem_wdata_o, 32'h1234_5678);
    check("st_rdata_hold", Read_Data_o, 32'hDEAD_BEEF);

    // Back-to-back loads
    run_txn(1'b1, 1'b0, 32'h30, 32'h0, 1, 32'h1111_1111, 1'b0, ns, nr, nb);
    check("bb1_stall_cycles", ns, 2);
    check("bb1_req_cycles", nr, 1);
    check("bb1_rdata", Read_Data_o, 32'h1111_1111);
    run_txn(1'b1, 1'b0, 32'h34, 32'h0, 1, 32'h2222_2222, 1'b0, ns, nr, nb);
    check("bb2_stall_cycles", ns, 2);
    check("bb2_req_cycles", nr, 1);
    check("bb2_addr", Mem_addr_o, 32'h34);
    check("bb2_rdata", Read_Data_o, 32'h2222_2222);

    // Both controls set is a store; inputs scrambled during WAIT must not leak through
    run_txn(1'b1, 1'b1, 32'h44, 32'hA5A5_0F0F, 3, 32'h0, 1'b1, ns, nr, nb);
    check("mut_stall_cycles", ns, 4);
    check("mut_addr", Mem_addr_o, 32'h44);
    check("mut_wdata", Mem_wdata_o, 32'hA5A5_0F0F);
    check("mut_we", {31'd0, Mem_we_o}, 32'd1);
    check("mut_rdata_hold", Read_Data_o, 32'h2222_2222);

    // Non-memory instructions
    @(negedge clk_i);
    MemRead_i = 1'b0; MemWrite_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("nop_stall", {31'd0, Stall_o}, 32'd0);
      check("nop_req", {31'd0, Mem_req_o}, 32'd0);
      @(negedge clk_i);
    end
    check("nop_rdata_hold", Read_Data_o, 32'h2222_2222);

    // Reset during WAIT, then a late ack
    MemRead_i = 1'b1; Addr_i = 32'h50;
    @(negedge clk_i);
    #1;
    check("rw_req_pre", {31'd0, Mem_req_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    check("rw_req", {31'd0, Mem_req_o}, 32'd0);
    check("rw_addr", Mem_addr_o, 32'd0);
    check("rw_rdata", Read_Data_o, 32'd0);
    check("rw_stall", {31'd0, Stall_o}, 32'd0);
    @(negedge clk_i);
    MemRead_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    Mem_ack_i = 1'b1; Mem_rdata_i = 32'h0000_CAFE;
    @(negedge clk_i);
    Mem_ack_i = 1'b0; Mem_rdata_i = 32'h0;
    #1;
    check("late_ack_rdata", Read_Data_o, 32'd0);
    check("late_ack_req", {31'd0, Mem_req_o}, 32'd0);
    run_txn(1'b1, 1'b0, 32'h60, 32'h0, 2, 32'h0BAD_F00D, 1'b0, ns, nr, nb);
    check("post_rst_stall", ns, 3);
    check("post_rst_rdata", Read_Data_o, 32'h0BAD_F00D);

`ifdef MEM_TIMEOUT_EN
    // Ack on the cycle the count hits zero wins
    run_txn(1'b1, 1'b0, 32'h70, 32'h0, 4, 32'h7777_7777, 1'b0, ns, nr, nb);
    check("tmo_race_req", nr, 4);
    check("tmo_race_rdata", Read_Data_o, 32'h7777_7777);
    check("tmo_race_flag", {31'd0, Timeout_o}, 32'd0);
    // No ack at all
    run_txn(1'b1, 1'b0, 32'h74, 32'h0, 0, 32'h0, 1'b0, ns, nr, nb);
    check("tmo_stall_cycles", ns, 5);
    check("tmo_req_cycles", nr, 4);
    check("tmo_flag", {31'd0, Timeout_o}, 32'd1);
    check("tmo_rdata", Read_Data_o, 32'd0);
    @(negedge clk_i);
    MemRead_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check("tmo_sticky", {31'd0, Timeout_o}, 32'd1);
    check("tmo_resume_stall", {31'd0, Stall_o}, 32'd0);
`else
    // Without the abort feature a slow ack simply extends the wait
    run_txn(1'b1, 1'b0, 32'h70, 32'h0, 30, 32'h7777_7777, 1'b0, ns, nr, nb);
    check("slow_stall_cycles", ns, 31);
    check("slow_req_cycles", nr, 30);
    check("slow_rdata", Read_Data_o, 32'h7777_7777);
    check("slow_tmo_flag", {31'd0, Timeout_o}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
